// File: rtl/gnn_aggregator_seq.sv
// Sequential GNN neighbour aggregator: programmable adjacency, SUM/MEAN/MAX with
// saturation, one destination node per cycle with all features in parallel.
module gnn_aggregator_seq #(
    parameter int NUM_NODES = 4,
    parameter int NUM_FEAT  = 4,
    parameter int DATA_W    = 21,
    parameter int IDX_W     = $clog2(NUM_NODES)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_rdy_agg,
    input  logic [1:0]                            mode,
    input  logic [NUM_NODES*NUM_FEAT*DATA_W-1:0]  x_in,
    input  logic                                  adj_we,
    input  logic [IDX_W-1:0]                      adj_row_idx,
    input  logic [NUM_NODES-1:0]                  adj_row_data,
    output logic                                  busy,
    output logic                                  out_rdy_agg,
    output logic [NUM_NODES*NUM_FEAT*DATA_W-1:0]  x_agg
);
    localparam int VEC_W = NUM_NODES * NUM_FEAT * DATA_W;
    localparam int SUM_W = DATA_W + IDX_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_HI  = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO  = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SUM_ONE = SUM_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_s;
    logic [IDX_W-1:0]            cnt_r;
    logic [1:0]                  mode_r;
    logic [VEC_W-1:0]            snap_r;
    logic [VEC_W-1:0]            x_agg_r;
    logic                        busy_r;
    logic                        out_rdy_r;
    logic [NUM_NODES-1:0]        adj_r [NUM_NODES];
    logic [NUM_NODES-1:0]        row_s;
    logic signed [DATA_W-1:0]    res_s [NUM_FEAT];

    function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[DATA_W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    assign busy        = busy_r;
    assign out_rdy_agg = out_rdy_r;
    assign x_agg       = x_agg_r;
    assign row_s       = adj_r[cnt_r];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_rdy_agg) state_s = ST_RUN;
                else            state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == IDX_W'(NUM_NODES - 1)) state_s = ST_DONE;
                else                                state_s = ST_RUN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Aggregate every feature of the current node over its neighbour set
    always_comb begin
        logic signed [SUM_W-1:0]  sum_v;
        logic signed [SUM_W-1:0]  cnt_v;
        logic signed [SUM_W-1:0]  quot_v;
        logic signed [DATA_W-1:0] elem_v;
        logic signed [DATA_W-1:0] max_v;
        sum_v  = '0;
        cnt_v  = '0;
        quot_v = '0;
        elem_v = '0;
        max_v  = '0;
        res_s  = '{default: '0};
        for (int f = 0; f < NUM_FEAT; f++) begin
            sum_v = '0;
            cnt_v = '0;
            max_v = {1'b1, {(DATA_W-1){1'b0}}};
            for (int j = 0; j < NUM_NODES; j++) begin
                elem_v = snap_r[(j*NUM_FEAT+f)*DATA_W +: DATA_W];
                if (row_s[j]) begin
                    sum_v = sum_v + SUM_W'(elem_v);
                    cnt_v = cnt_v + SUM_ONE;
                    if (elem_v > max_v) max_v = elem_v;
                    else                max_v = max_v;
                end else begin
                    sum_v = sum_v;
                end
            end
            // Divisor forced to one on an empty row; that result is discarded below
            quot_v = sum_v / ((cnt_v == '0) ? SUM_ONE : cnt_v);
            if (cnt_v == '0) begin
                res_s[f] = '0;
            end else begin
                case (mode_r)
                    2'b01:   res_s[f] = sat_fn(quot_v);
                    2'b10:   res_s[f] = max_v;
                    default: res_s[f] = sat_fn(sum_v);
                endcase
            end
        end
    end

    // Datapath, adjacency storage and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            mode_r    <= 2'b00;
            snap_r    <= '0;
            x_agg_r   <= '0;
            busy_r    <= 1'b0;
            out_rdy_r <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                adj_r[i] <= NUM_NODES'(1) << i;
            end
        end else begin
            busy_r    <= (state_s != ST_IDLE);
            out_rdy_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (in_rdy_agg) begin
                        snap_r <= x_in;
                        mode_r <= mode;
                        cnt_r  <= '0;
                    end
                    if (adj_we && (int'(adj_row_idx) < NUM_NODES)) begin
                        adj_r[adj_row_idx] <= adj_row_data;
                    end
                end
                ST_RUN: begin
                    for (int f = 0; f < NUM_FEAT; f++) begin
                        x_agg_r[(int'(cnt_r)*NUM_FEAT+f)*DATA_W +: DATA_W] <= res_s[f];
                    end
                    cnt_r <= cnt_r + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gnn_aggregator_seq.sv
// Scoreboard bench for gnn_aggregator_seq: runs push hand-computed results, a
// negedge monitor pops and compares on every out_rdy_agg pulse.
module tb_gnn_aggregator_seq;
    localparam int N  = 4;
    localparam int F  = 4;
    localparam int W  = 21;
    localparam int IW = 2;
    localparam int VW = N * F * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_rdy_agg;
    logic [1:0]    mode;
    logic [VW-1:0] x_in;
    logic          adj_we;
    logic [IW-1:0] adj_row_idx;
    logic [N-1:0]  adj_row_data;
    logic          busy;
    logic          out_rdy_agg;
    logic [VW-1:0] x_agg;

    int            total = 0;
    int            bad   = 0;
    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] mon_exp;
    logic          prev_rdy = 1'b0;

    always #5 clk = ~clk;

    gnn_aggregator_seq #(.NUM_NODES(N), .NUM_FEAT(F), .DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_rdy_agg  (in_rdy_agg),
        .mode        (mode),
        .x_in        (x_in),
        .adj_we      (adj_we),
        .adj_row_idx (adj_row_idx),
        .adj_row_data(adj_row_data),
        .busy        (busy),
        .out_rdy_agg (out_rdy_agg),
        .x_agg       (x_agg)
    );

    // Monitor: every pulse must be single-cycle and match the oldest pending result
    always @(negedge clk) begin
        if (out_rdy_agg) begin
            total++;
            if (prev_rdy) begin
                bad++;
                $display("FAIL rdy_width: out_rdy_agg high two cycles in a row, required one");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rdy: out_rdy_agg pulse with no run pending, required none");
            end else begin
                mon_exp = exp_q.pop_front();
                if (x_agg !== mon_exp) begin
                    bad++;
                    $display("FAIL x_agg: got %h required %h", x_agg, mon_exp);
                end
            end
        end
        prev_rdy = out_rdy_agg;
    end

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int n, input int f, input int val);
        logic [W-1:0] e;
        e = val[W-1:0];
        v[(n*F+f)*W +: W] = e;
        return v;
    endfunction

    function automatic logic [VW-1:0] fill(input int val);
        logic [VW-1:0] v;
        v = '0;
        for (int n = 0; n < N; n++)
            for (int f = 0; f < F; f++)
                v = put(v, n, f, val);
        return v;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic prog_row(input int r, input logic [N-1:0] d);
        adj_we       = 1'b1;
        adj_row_idx  = r[IW-1:0];
        adj_row_data = d;
        @(negedge clk);
        adj_we = 1'b0;
    endtask

    task automatic prog_all(input logic [N-1:0] r0, input logic [N-1:0] r1,
                            input logic [N-1:0] r2, input logic [N-1:0] r3);
        prog_row(0, r0);
        prog_row(1, r1);
        prog_row(2, r2);
        prog_row(3, r3);
    endtask

    // Start at a negedge; the start edge is T, pulse expected in the cycle after T+5
    task automatic run(input string name, input logic [1:0] m, input logic [VW-1:0] x,
                       input logic [VW-1:0] e, input bit inject);
        int lat;
        int bcnt;
        exp_q.push_back(e);
        mode       = m;
        x_in       = x;
        in_rdy_agg = 1'b1;
        @(negedge clk);
        in_rdy_agg = 1'b0;
        mode       = ~m;
        x_in       = '1;
        lat  = 1;
        bcnt = 0;
        while (!out_rdy_agg && lat < 20) begin
            if (busy) bcnt++;
            if (inject && lat == 2) begin
                in_rdy_agg   = 1'b1;
                adj_we       = 1'b1;
                adj_row_idx  = 2'd3;
                adj_row_data = 4'b1111;
            end else begin
                in_rdy_agg = 1'b0;
                adj_we     = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_rdy_agg = 1'b0;
        adj_we     = 1'b0;
        chk_int({name, "_latency"}, lat, 6);
        chk_int({name, "_busy_cycles"}, bcnt, 5);
    endtask

    logic [VW-1:0] xa;
    logic [VW-1:0] xv;
    logic [VW-1:0] ev;

    initial begin
        rst = 1'b1; in_rdy_agg = 1'b0; adj_we = 1'b0; mode = 2'b00;
        x_in = '0; adj_row_idx = '0; adj_row_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_rdy", int'(out_rdy_agg), 0);
        chk("reset_x_agg", x_agg, '0);

        xa = '0;
        for (int n = 0; n < N; n++)
            for (int f = 0; f < F; f++)
                xa = put(xa, n, f, 10 * n + f);

        // Identity adjacency passes features through; mode 11 behaves as SUM
        run("t1_identity", 2'b00, xa, xa, 1'b0);
        run("t1_mode11", 2'b11, xa, xa, 1'b0);

        // Leave-one-out rows, feature 0 = 1,2,3,4
        prog_all(4'b0111, 4'b1011, 4'b1101, 4'b1110);
        xv = '0; ev = '0;
        for (int n = 0; n < N; n++) xv = put(xv, n, 0, n + 1);
        ev = put(ev, 0, 0, 6); ev = put(ev, 1, 0, 7);
        ev = put(ev, 2, 0, 8); ev = put(ev, 3, 0, 9);
        run("t2_sum", 2'b00, xv, ev, 1'b0);

        // Saturation at both rails with a full adjacency
        prog_all(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        run("t3_sat_hi", 2'b00, fill(1048575), fill(1048575), 1'b0);
        run("t3_sat_lo", 2'b00, fill(-1048576), fill(-1048576), 1'b0);

        // MEAN: row0 = nodes 0..2, row1 empty, rows 2/3 self only
        prog_all(4'b0111, 4'b0000, 4'b0100, 4'b1000);
        xv = '0; xv = put(xv, 0, 0, 5); xv = put(xv, 1, 0, -7); xv = put(xv, 2, 0, 10);
        ev = '0; ev = put(ev, 0, 0, 2); ev = put(ev, 2, 0, 10);
        run("t4_mean_pos", 2'b01, xv, ev, 1'b0);
        xv = '0; xv = put(xv, 0, 0, -5); xv = put(xv, 1, 0, -7); xv = put(xv, 2, 0, 4);
        ev = '0; ev = put(ev, 0, 0, -2); ev = put(ev, 2, 0, 4);
        run("t4_mean_neg", 2'b01, xv, ev, 1'b0);

        // MAX with the same adjacency
        xv = '0; xv = put(xv, 0, 0, -3); xv = put(xv, 1, 0, 9); xv = put(xv, 2, 0, 4);
        ev = '0; ev = put(ev, 0, 0, 9); ev = put(ev, 2, 0, 4);
        run("t5_max", 2'b10, xv, ev, 1'b0);
        xv = '0; xv = put(xv, 0, 0, -3); xv = put(xv, 1, 0, -9); xv = put(xv, 2, 0, -4);
        ev = '0; ev = put(ev, 0, 0, -3); ev = put(ev, 2, 0, -4);
        run("t5_max_neg", 2'b10, xv, ev, 1'b0);

        // Start and row-3 write during RUN are both ignored
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        run("t6_inject", 2'b00, xa, xa, 1'b1);
        repeat (8) @(negedge clk);
        run("t6_after_inject", 2'b00, xa, xa, 1'b0);

        // Reset mid-run: no pulse, outputs cleared, adjacency back to identity
        prog_all(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        mode = 2'b00; x_in = xa; in_rdy_agg = 1'b1;
        @(negedge clk);
        in_rdy_agg = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_int("t6_rst_busy", int'(busy), 0);
        chk_int("t6_rst_rdy", int'(out_rdy_agg), 0);
        chk("t6_rst_x_agg", x_agg, '0);
        repeat (10) @(negedge clk);
        xv = fill(-17);
        run("t6_post_reset_identity", 2'b00, xv, xv, 1'b0);

        repeat (5) @(negedge clk);
        chk_int("pending_results", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gnn_aggregator_seq.md
Name: gnn_aggregator_seq

Overview:
Parametrised successor to the fixed 4-node/4-feature neighbour aggregator. It holds a runtime-programmable adjacency matrix and supports SUM, MEAN and MAX aggregation with saturation. It processes one node per cycle (all features of that node in parallel) under a small FSM. It sits between the feature load stage and the combination/weight stage of the GNN layer pipeline.

Parameters:
NUM_NODES, 4, number of graph nodes (2..16)
NUM_FEAT, 4, features per node
DATA_W, 21, signed feature width (inputs and outputs)
IDX_W, $clog2(NUM_NODES), node index width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_rdy_agg  in  1  start pulse; sampled only in IDLE
mode  in  2  00=SUM, 01=MEAN, 10=MAX, 11=SUM; latched at start
x_in  in  NUM_NODES*NUM_FEAT*DATA_W  flattened features, element (n,f) at bit offset (n*NUM_FEAT+f)*DATA_W
adj_we  in  1  adjacency row write strobe
adj_row_idx  in  IDX_W  row (destination node) to write
adj_row_data  in  NUM_NODES  bit j=1: node j contributes to the row node (self-loop explicit)
busy  out  1  high in RUN and DONE
out_rdy_agg  out  1  one-cycle pulse: x_agg complete
x_agg  out  NUM_NODES*NUM_FEAT*DATA_W  aggregated features, same packing as x_in

Behaviour:
- Reset (clk edge with rst=1, any state, including mid-RUN): FSM->IDLE; busy=0; out_rdy_agg=0; x_agg=0; node counter=0; adjacency=identity (self-loops only). An aborted run produces no out_rdy_agg pulse.
- FSM states and transitions:
  - IDLE: on in_rdy_agg=1, capture x_in into an internal snapshot, latch mode, clear counter, go to RUN.
  - RUN: each cycle compute node i=counter for all features and register the result into x_agg slot i. Counter increments; after i=NUM_NODES-1, go to DONE.
  - DONE: out_rdy_agg=1 for exactly this cycle, then IDLE.
- Timing: in_rdy_agg sampled at edge T. Node i written at edge T+1+i. out_rdy_agg is high in the cycle after edge T+NUM_NODES+1 and low again after edge T+NUM_NODES+2. busy spans the same window, through DONE.
- x_in may change after the start edge; the snapshot is used. x_agg slots update progressively during RUN and are valid only from out_rdy_agg onward. x_agg holds until the next run overwrites it.
- in_rdy_agg in RUN/DONE: ignored, not queued. Back-to-back starts are accepted in the first IDLE cycle.
- adj_we: honoured only in IDLE (written at the clock edge). Ignored when busy. Adjacency rows are not latched per run; they are stable because writes are blocked while busy.
- Arithmetic per (i,f) over neighbour set S = {j : adj[i][j]=1}:
  - SUM: full-precision signed sum (DATA_W+IDX_W+1 bits), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - MEAN: full-precision sum / |S|, signed, truncation toward zero. No saturation is needed.
  - MAX: signed maximum over S.
  - Empty S (row all zero): result 0 in every mode.
- Simultaneous rst with in_rdy_agg or adj_we: rst wins.

Test Plan:
1. Reset, identity adjacency, SUM, x(n,f)=10n+f, start at T -> x_agg==x_in, out_rdy_agg single pulse after edge T+5, busy high for 5 cycles.
2. Program rows 0..3 = 0111,1011,1101,1110 (bit j = node j), SUM, feature0 of nodes 0..3 = 1,2,3,4 -> agg feature0 = 6,7,8,9.
3. Full adjacency, SUM, all inputs 1048575 -> all outputs 1048575; all inputs -1048576 -> all outputs -1048576 (saturation).
4. MEAN, row0=0111, node0..2 feat0 = 5,-7,10 -> 2; node0..2 feat0 = -5,-7,4 -> -2 (toward zero); row1=0000 -> 0.
5. MAX, row0=0111, node0..2 = -3,9,4 -> 9; all-negative -3,-9,-4 -> -3; empty row -> 0.
6. in_rdy_agg and adj_we asserted at T+2 -> both ignored (adjacency unchanged, one out_rdy_agg pulse). New run with rst at T+2 -> busy=0, x_agg=0, adjacency=identity, no out_rdy_agg pulse.
